vreg_wb_ctrl: RTL and testbench
===============================

// Module: vreg_wb_ctrl
// PURPOSE
//  Write-side master for vreg_file: buffers vector results from execute units in a small FIFO and
//  drains them one per cycle onto the register file write port (wen/vd/wdata). Also provides a
//  forwarding lookup so readers see buffered, not-yet-written values. It sits between the vector
//  ALU result bus and vreg_file.
// PARAMETERS
//  DEPTH  4   write-buffer entries; power of 2, >= 2
//  VLEN   64  vector register width in bits
// PORTS
//  clk       in   1     clock; all state updates on posedge
//  rst       in   1     reset, asynchronous, active-high
//  in_valid  in   1     result available from execute unit
//  in_ready  out  1     buffer can accept a result this cycle
//  in_vd     in   5     destination register index of result
//  in_data   in   VLEN  result value
//  wb_stall  in   1     write port borrowed by another master; hold the drain
//  wen       out  1     to vreg_file.wen
//  vd        out  5     to vreg_file.vd
//  wdata     out  VLEN  to vreg_file.wdata
//  q_vs1     in   5     forwarding query, read port 1 index
//  q_vs2     in   5     forwarding query, read port 2 index
//  q_hit1    out  1     pending write to q_vs1 exists
//  q_hit2    out  1     pending write to q_vs2 exists
//  q_data1   out  VLEN  youngest pending value for q_vs1 (0 when no hit)
//  q_data2   out  VLEN  youngest pending value for q_vs2 (0 when no hit)
//  count     out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset (asynchronous on rst=1): wr/rd pointers and count = 0, all entries invalid. While reset is
//    held: wen=0, in_ready=1, q_hit*=0, q_data*=0, count=0. An in-flight handshake is discarded.
//  - Accept: the handshake is in_valid && in_ready. in_ready = (count != DEPTH), with no
//    combinational dependence on the drain. When full, a simultaneous pop does not let a push in.
//  - in_vd==0 results are handshaken (consumed) but never enqueued; count is unchanged by them.
//  - Drain: wen = (count != 0) && !wb_stall, combinational. vd and wdata come from the head entry
//    (0 when empty). When wen=1, the head is popped at the posedge, so vreg_file captures it on the
//    same edge.
//  - Latency: a result accepted at edge N into an empty buffer drives wen=1 in cycle N+1 and
//    lands in the register file at edge N+1.
//  - Simultaneous push+pop: count is unchanged; the pointers wrap modulo DEPTH.
//  - Order: writes reach vreg_file in acceptance order. Several entries may share one vd; the
//    last write wins.
//  - Forwarding (combinational): q_hitK = (q_vsK != 0) and some valid entry, including the head
//    being written this cycle, has vd == q_vsK. q_dataK is the youngest such entry (closest to
//    the tail). A result being pushed in the same cycle is NOT visible until the next cycle.
//  - wb_stall held high: the buffer fills, and in_ready drops once count == DEPTH. Forwarding stays valid.
// TESTING
//  1. rst pulse mid-cycle with 3 entries queued -> count=0, wen=0, in_ready=1 immediately (async).
//  2. push vd=5, data=64'hA5A5 into empty buffer, wb_stall=0 -> next cycle wen=1, vd=5, wdata=A5A5;
//     a vreg_file read of v5 returns A5A5 after that edge.
//  3. wb_stall=1, push vd=1..5 with data 1..5 -> in_ready=0 after 4 pushes (DEPTH=4), count=4;
//     release stall -> wen=1 for 4 consecutive cycles with vd=1,2,3,4.
//  4. stall, push vd=7 data=11 then vd=7 data=22 -> q_vs1=7 gives q_hit1=1, q_data1=22; q_vs2=0 gives
//     q_hit2=0, q_data2=0 even while vd=0 input is pending.
//  5. push vd=0 data=FFFF -> handshake completes, count stays 0, wen never asserted.
//  6. full buffer, stall released, in_valid=1 same cycle -> that cycle pop only (count 4->3); push
//     accepted next cycle; continuous push/pop at count=2 keeps count=2 across pointer wrap.

Source files
------------

// File: rtl/vreg_wb_ctrl.sv
// Write-back buffer for vreg_file: queues execute-unit results, drains one per cycle
// onto the register-file write port, and forwards the youngest pending value per register.
module vreg_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int VLEN  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_vd,
  input  logic [VLEN-1:0]          in_data,
  input  logic                     wb_stall,
  output logic                     wen,
  output logic [4:0]               vd,
  output logic [VLEN-1:0]          wdata,
  input  logic [4:0]               q_vs1,
  input  logic [4:0]               q_vs2,
  output logic                     q_hit1,
  output logic                     q_hit2,
  output logic [VLEN-1:0]          q_data1,
  output logic [VLEN-1:0]          q_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [4:0]      mem_vd   [DEPTH];
  logic [VLEN-1:0] mem_data [DEPTH];
  logic            push;
  logic            pop;

  // Results targeting v0 are consumed by the handshake but never stored.
  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready && (in_vd != 5'd0);
  assign pop      = wen;

  assign wen   = (count != '0) && !wb_stall;
  assign vd    = (count != '0) ? mem_vd[rd_ptr]   : 5'd0;
  assign wdata = (count != '0) ? mem_data[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Entry storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_vd[wr_ptr]   <= in_vd;
      mem_data[wr_ptr] <= in_data;
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest pending write.
  always_comb begin
    q_hit1  = 1'b0;
    q_hit2  = 1'b0;
    q_data1 = '0;
    q_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        if ((q_vs1 != 5'd0) && (mem_vd[rd_ptr + AW'(k)] == q_vs1)) begin
          q_hit1  = 1'b1;
          q_data1 = mem_data[rd_ptr + AW'(k)];
        end
        if ((q_vs2 != 5'd0) && (mem_vd[rd_ptr + AW'(k)] == q_vs2)) begin
          q_hit2  = 1'b1;
          q_data2 = mem_data[rd_ptr + AW'(k)];
        end
      end
    end
  end

endmodule

// File: tb/tb_vreg_wb_ctrl.sv
// Bench for vreg_wb_ctrl: directed scenarios then random traffic, all checked against
// a queue-based model of the pending-write list.
module tb_vreg_wb_ctrl;
  localparam int DEPTH = 4;
  localparam int VLEN  = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_vd;
  logic [VLEN-1:0] in_data;
  logic            wb_stall;
  logic            wen;
  logic [4:0]      vd;
  logic [VLEN-1:0] wdata;
  logic [4:0]      q_vs1, q_vs2;
  logic            q_hit1, q_hit2;
  logic [VLEN-1:0] q_data1, q_data2;
  logic [2:0]      count;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0]      mvd  [$];
  logic [VLEN-1:0] mdat [$];

  always #5 clk = ~clk;

  vreg_wb_ctrl #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vd(in_vd),
    .in_data(in_data), .wb_stall(wb_stall), .wen(wen), .vd(vd), .wdata(wdata),
    .q_vs1(q_vs1), .q_vs2(q_vs2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .q_data1(q_data1), .q_data2(q_data2), .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest pending value for a register, scanning from the tail of the list.
  task automatic fwd(input logic [4:0] vs, output logic hit, output logic [VLEN-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (vs != 5'd0) begin
      for (int i = mvd.size() - 1; i >= 0; i--) begin
        if (mvd[i] == vs) begin
          hit = 1'b1;
          d   = mdat[i];
          break;
        end
      end
    end
  endtask

  task automatic check_all();
    logic            h;
    logic [VLEN-1:0] d;
    if (rst) begin
      mvd.delete();
      mdat.delete();
    end
    chk("in_ready", in_ready, mvd.size() != DEPTH);
    chk("wen",      wen,      (mvd.size() != 0) && !wb_stall);
    chk("vd",       vd,       (mvd.size() != 0) ? mvd[0]  : 5'd0);
    chk("wdata",    wdata,    (mvd.size() != 0) ? mdat[0] : 64'd0);
    chk("count",    count,    mvd.size());
    fwd(q_vs1, h, d);
    chk("q_hit1",  q_hit1,  h);
    chk("q_data1", q_data1, d);
    fwd(q_vs2, h, d);
    chk("q_hit2",  q_hit2,  h);
    chk("q_data2", q_data2, d);
  endtask

  // One clock: check combinational outputs at the falling edge, then advance the model.
  task automatic cycle();
    bit do_pop, do_push;
    @(negedge clk);
    check_all();
    do_pop  = (mvd.size() != 0) && !wb_stall;
    do_push = in_valid && (mvd.size() != DEPTH) && (in_vd != 5'd0);
    @(posedge clk);
    if (rst) begin
      mvd.delete();
      mdat.delete();
    end else begin
      if (do_pop) begin
        void'(mvd.pop_front());
        void'(mdat.pop_front());
      end
      if (do_push) begin
        mvd.push_back(in_vd);
        mdat.push_back(in_data);
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_vd = '0; in_data = '0; wb_stall = 1'b0;
    q_vs1 = '0; q_vs2 = '0;
    @(posedge clk); #1;
    // Handshake offered while reset is held must be dropped.
    in_valid = 1'b1; in_vd = 5'd3; in_data = 64'h33; q_vs1 = 5'd3;
    cycle(); cycle();
    rst = 1'b0; in_valid = 1'b0;
    cycle();

    // Asynchronous reset in the middle of a cycle with three entries queued.
    wb_stall = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_vd = 5'(i + 10); in_data = 64'(i * 100);
      cycle();
    end
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("rst_count",    count,    3'd0);
    chk("rst_wen",      wen,      1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    mvd.delete(); mdat.delete();
    @(posedge clk); #1;
    rst = 1'b0; wb_stall = 1'b0;

    // Single push into an empty buffer reaches the write port next cycle.
    in_valid = 1'b1; in_vd = 5'd5; in_data = 64'hA5A5; q_vs1 = 5'd5;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();

    // Stalled fill: fifth push is refused, then four consecutive drains.
    wb_stall = 1'b1; in_valid = 1'b1; q_vs1 = 5'd2; q_vs2 = 5'd4;
    for (int i = 1; i <= 5; i++) begin
      in_vd = 5'(i); in_data = 64'(i);
      cycle();
    end
    in_valid = 1'b0; wb_stall = 1'b0;
    for (int i = 0; i < 5; i++) cycle();

    // Duplicate destinations: youngest forwarded; same-cycle push stays invisible.
    wb_stall = 1'b1; in_valid = 1'b1; q_vs1 = 5'd7; q_vs2 = 5'd0;
    in_vd = 5'd7; in_data = 64'd11; cycle();
    in_vd = 5'd7; in_data = 64'd22; cycle();
    in_vd = 5'd0; in_data = 64'hDEAD; cycle();
    in_vd = 5'd7; in_data = 64'd33; cycle();
    in_valid = 1'b0; cycle();
    wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // v0 results are consumed but never queued.
    in_valid = 1'b1; in_vd = 5'd0; in_data = 64'hFFFF; q_vs1 = 5'd0;
    cycle(); cycle();
    in_valid = 1'b0; cycle();

    // Full buffer with simultaneous release and push, then steady push/pop at depth two.
    wb_stall = 1'b1; in_valid = 1'b1; q_vs1 = 5'd9;
    for (int i = 0; i < 4; i++) begin
      in_vd = 5'(20 + i); in_data = 64'(1000 + i);
      cycle();
    end
    wb_stall = 1'b0; in_vd = 5'd9; in_data = 64'h99;
    cycle();
    cycle();
    in_valid = 1'b0; cycle();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_vd = 5'(9 + (i % 3)); in_data = 64'(5000 + i);
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Random traffic with a narrow register range to provoke forwarding collisions.
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 99) < 2);
      in_valid = $urandom_range(0, 1);
      in_vd    = 5'($urandom_range(0, 7));
      in_data  = {$urandom, $urandom};
      wb_stall = ($urandom_range(0, 9) < 4);
      q_vs1    = 5'($urandom_range(0, 7));
      q_vs2    = 5'($urandom_range(0, 7));
      cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
